// File: rtl/stream_demux.sv
// Stream demultiplexer: one valid/ready input steered into NUM_ELEM one-entry output registers, unicast or broadcast.
// Optional saturating drop counter on drop_cnt_o, enabled by defining STREAM_DEMUX_DROP_CNT_EN.
module stream_demux #(
    parameter int unsigned NUM_ELEM   = 6,
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned SEL_W     = $clog2(NUM_ELEM)
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic [SEL_W-1:0]                     s_i,
    input  logic                                 bcast_i,
    input  logic [ELEM_WIDTH-1:0]                i_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  o_o,
    output logic [NUM_ELEM-1:0]                  valid_o,
    input  logic [NUM_ELEM-1:0]                  ready_i
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]                 drop_cnt_o
`endif
);

    logic [NUM_ELEM-1:0]                 free;
    logic [NUM_ELEM-1:0]                 sel_hot;
    logic [NUM_ELEM-1:0]                 load;
    logic [NUM_ELEM-1:0]                 valid_q, valid_d;
    logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] data_q, data_d;
    logic                                in_range;
    logic                                xfer;

    always_comb begin
        free     = '0;
        sel_hot  = '0;
        load     = '0;
        valid_d  = valid_q;
        data_d   = data_q;
        in_range = 32'(s_i) < NUM_ELEM;

        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
            free[k]    = !valid_q[k] || ready_i[k];
            sel_hot[k] = 32'(s_i) == k;
        end

        // Out-of-range selects are always accepted so the source never stalls on a dropped beat.
        if (bcast_i)
            ready_o = &free;
        else if (in_range)
            ready_o = |(free & sel_hot);
        else
            ready_o = 1'b1;

        xfer = valid_i && ready_o;

        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
            load[k] = xfer && (bcast_i || sel_hot[k]);
            if (load[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = i_i;
            end else if (ready_i[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign o_o     = data_q;

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic                 drop;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        drop  = xfer && !bcast_i && !in_range;
        cnt_d = cnt_q;
        if (drop && (cnt_q != '1))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign drop_cnt_o = cnt_q;
`else
    logic unused_cnt_width;
    assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed vector table, hand-written corner sequences, random soak vs queue model.
module tb_stream_demux;

    localparam int unsigned N = 6;
    localparam int unsigned W = 8;

    logic                 clk = 1'b0;
    logic                 srst;
    logic [2:0]           s;
    logic                 bcast;
    logic [W-1:0]         din;
    logic                 vin;
    logic                 rdy_o;
    logic [N-1:0][W-1:0]  dout;
    logic [N-1:0]         vld;
    logic [N-1:0]         rdy;

    always #5 clk = ~clk;

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0]          drops;
    logic                 srst2;
    logic [2:0]           s2;
    logic                 vin2;
    logic                 rdy2_o;
    logic [N-1:0][W-1:0]  dout2;
    logic [N-1:0]         vld2;
    logic [1:0]           drops2;
`endif

    stream_demux #(.NUM_ELEM(N), .ELEM_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk_i     (clk),
        .srst_i    (srst),
        .s_i       (s),
        .bcast_i   (bcast),
        .i_i       (din),
        .valid_i   (vin),
        .ready_o   (rdy_o),
        .o_o       (dout),
        .valid_o   (vld),
        .ready_i   (rdy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt_o(drops)
`endif
    );

`ifdef STREAM_DEMUX_DROP_CNT_EN
    stream_demux #(.NUM_ELEM(N), .ELEM_WIDTH(W), .CNT_WIDTH(2)) dut_sat (
        .clk_i     (clk),
        .srst_i    (srst2),
        .s_i       (s2),
        .bcast_i   (1'b0),
        .i_i       (8'h00),
        .valid_i   (vin2),
        .ready_o   (rdy2_o),
        .o_o       (dout2),
        .valid_o   (vld2),
        .ready_i   ({N{1'b1}}),
        .drop_cnt_o(drops2)
    );
`endif

    typedef struct {
        logic [2:0]   s;
        logic         b;
        logic         v;
        logic [N-1:0] rdy;
        logic [W-1:0] d;
        logic         exp_rdy;
        logic [N-1:0] exp_vld;
        int unsigned  ch;
        logic [W-1:0] exp_dat;
        int unsigned  exp_drops;
    } vec_t;

    vec_t         tbl[10];
    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;

    logic [W-1:0] mq[N][$];
    int unsigned  pushed, popped, dut_popped, mdrops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst  = 1'b1;
        vin   = 1'b0;
        bcast = 1'b0;
        rdy   = '1;
        tick();
        srst  = 1'b0;
    endtask

    task automatic soak_check();
        for (int k = 0; k < N; k++) begin
            check($sformatf("soak_valid%0d", k), 64'(vld[k]), 64'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                check($sformatf("soak_data%0d", k), 64'(dout[k]), 64'(mq[k][0]));
        end
    endtask

    initial begin
        logic er;

        tbl[0] = '{3'd3, 1'b0, 1'b1, 6'h3F, 8'hA5, 1'b1, 6'b001000, 3, 8'hA5, 0};
        tbl[1] = '{3'd1, 1'b0, 1'b1, 6'h3F, 8'h3C, 1'b1, 6'b000010, 1, 8'h3C, 0};
        tbl[2] = '{3'd1, 1'b0, 1'b1, 6'h3D, 8'h77, 1'b0, 6'b000010, 1, 8'h3C, 0};
        tbl[3] = '{3'd1, 1'b0, 1'b1, 6'h3F, 8'h77, 1'b1, 6'b000010, 1, 8'h77, 0};
        tbl[4] = '{3'd0, 1'b1, 1'b1, 6'h3D, 8'h5C, 1'b0, 6'b000010, 1, 8'h77, 0};
        tbl[5] = '{3'd0, 1'b1, 1'b1, 6'h3F, 8'h5C, 1'b1, 6'b111111, 4, 8'h5C, 0};
        tbl[6] = '{3'd6, 1'b0, 1'b1, 6'h00, 8'hEE, 1'b1, 6'b111111, 2, 8'h5C, 1};
        tbl[7] = '{3'd7, 1'b0, 1'b0, 6'h3F, 8'hEE, 1'b1, 6'b000000, 0, 8'h5C, 1};
        tbl[8] = '{3'd2, 1'b0, 1'b0, 6'h00, 8'hFF, 1'b1, 6'b000000, 2, 8'h5C, 1};
        tbl[9] = '{3'd5, 1'b0, 1'b1, 6'h00, 8'hE1, 1'b1, 6'b100000, 5, 8'hE1, 1};

        s   = '0;
        din = '0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        srst2 = 1'b1;
        vin2  = 1'b0;
        s2    = 3'd6;
`endif
        do_reset();

        // Reset state
        @(negedge clk);
        check("reset_valid", 64'(vld), 64'(0));
        check("reset_data", 64'(dout), 64'(0));
        check("reset_ready", 64'(rdy_o), 64'(1));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("reset_drops", 64'(drops), 64'(0));
`endif
        tick();

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            s = tbl[i].s; bcast = tbl[i].b; vin = tbl[i].v; rdy = tbl[i].rdy; din = tbl[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 64'(rdy_o), 64'(tbl[i].exp_rdy));
            tick();
            check($sformatf("vec%0d_valid", i), 64'(vld), 64'(tbl[i].exp_vld));
            check($sformatf("vec%0d_data", i), 64'(dout[tbl[i].ch]), 64'(tbl[i].exp_dat));
`ifdef STREAM_DEMUX_DROP_CNT_EN
            check($sformatf("vec%0d_drops", i), 64'(drops), 64'(tbl[i].exp_drops));
`endif
        end

        // Backpressure on channel 2, release in the same cycle
        do_reset();
        s = 3'd2; din = 8'h11; vin = 1'b1; rdy = '0;
        tick();
        din = 8'h22;
        @(negedge clk);
        check("bp_ready_stall", 64'(rdy_o), 64'(0));
        tick();
        check("bp_hold", 64'(dout[2]), 64'(8'h11));
        rdy = 6'b000100;
        @(negedge clk);
        check("bp_ready_release", 64'(rdy_o), 64'(1));
        tick();
        check("bp_new_data", 64'(dout[2]), 64'(8'h22));
        check("bp_valid", 64'(vld), 64'(6'b000100));

        // Broadcast blocked by a stalled channel 4
        do_reset();
        s = 3'd4; din = 8'h99; vin = 1'b1; rdy = '0;
        tick();
        bcast = 1'b1; din = 8'h5C;
        @(negedge clk);
        check("bc_ready_stall", 64'(rdy_o), 64'(0));
        tick();
        check("bc_hold", 64'(dout[4]), 64'(8'h99));
        rdy = '1;
        @(negedge clk);
        check("bc_ready_release", 64'(rdy_o), 64'(1));
        tick();
        check("bc_valid", 64'(vld), 64'(6'h3F));
        check("bc_data", 64'(dout), 64'({N{8'h5C}}));
        bcast = 1'b0; vin = 1'b0;

        // Out-of-range selects are dropped
        do_reset();
        vin = 1'b1; rdy = '0; din = 8'h42;
        for (int i = 0; i < 3; i++) begin
            s = (i == 1) ? 3'd7 : 3'd6;
            @(negedge clk);
            check($sformatf("drop%0d_ready", i), 64'(rdy_o), 64'(1));
            tick();
        end
        vin = 1'b0;
        check("drop_no_valid", 64'(vld), 64'(0));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("drop_count", 64'(drops), 64'(3));
        srst2 = 1'b0; vin2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s2 = (i % 2 == 0) ? 3'd6 : 3'd7;
            tick();
        end
        vin2 = 1'b0;
        check("drop_saturate", 64'(drops2), 64'(3));
`endif

        // Reset overrides a same-cycle transfer with stalled channels holding data
        do_reset();
        rdy = '0; vin = 1'b1;
        s = 3'd0; din = 8'hAA; tick();
        s = 3'd5; din = 8'hBB; tick();
        check("rst_pre_valid", 64'(vld), 64'(6'b100001));
        srst = 1'b1; s = 3'd1; din = 8'hCC;
        tick();
        srst = 1'b0; vin = 1'b0;
        check("rst_valid", 64'(vld), 64'(0));
        check("rst_data", 64'(dout), 64'(0));

        // Random soak against per-channel queue model
        do_reset();
        pushed = 0; popped = 0; dut_popped = 0; mdrops = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            s     = 3'($urandom_range(0, 7));
            bcast = ($urandom_range(0, 7) == 0);
            vin   = ($urandom_range(0, 3) != 0);
            rdy   = 6'($urandom);
            din   = 8'($urandom);
            @(negedge clk);
            if (bcast) begin
                er = 1'b1;
                for (int k = 0; k < N; k++)
                    if (mq[k].size() != 0 && !rdy[k]) er = 1'b0;
            end else if (s < N) begin
                er = (mq[s].size() == 0) || rdy[s];
            end else begin
                er = 1'b1;
            end
            check("soak_ready", 64'(rdy_o), 64'(er));
            soak_check();
            for (int k = 0; k < N; k++) begin
                if (vld[k] && rdy[k]) dut_popped++;
                if (mq[k].size() != 0 && rdy[k]) begin
                    void'(mq[k].pop_front());
                    popped++;
                end
            end
            if (vin && er) begin
                if (bcast) begin
                    for (int k = 0; k < N; k++) begin
                        mq[k].push_back(din);
                        pushed++;
                    end
                end else if (s < N) begin
                    mq[s].push_back(din);
                    pushed++;
                end else begin
                    mdrops++;
                end
            end
            tick();
        end
        vin = 1'b0;
        @(negedge clk);
        soak_check();
        check("soak_delivered", 64'(dut_popped), 64'(popped));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("soak_drops", 64'(drops), 64'(mdrops));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
